// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between instruction
// fetch and the load/store path. Load/store normally wins; each transaction
// is held on the memory port until mem_ack, then the owner's rdata is
// registered and its rvalid pulses for one cycle.
//
// Optional feature macro: ARB_ANTI_STARVE_EN (anti-starvation for fetch).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               discards fetch traffic (pending grant and in-flight data)
//   if_req/if_addr      fetch read request      -> if_gnt, if_rvalid, if_rdata
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata
//                       load/store request      -> ls_gnt, ls_rvalid, ls_rdata
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   registered memory command
//   mem_ack/mem_rdata   memory completion and read data
//   stall               ls_req & ~ls_rvalid, toward hazard detection
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              drop_q, drop_d;
    logic              if_ok_c;
    logic              force_if_c;

`ifdef ARB_ANTI_STARVE_EN
    logic [CNT_W-1:0]  starve_q, starve_d;

    // Fetch is forced through once the LS path has won STARVE_MAX times in a row.
    assign force_if_c = if_ok_c && (starve_q == CNT_W'(STARVE_MAX));
`else
    logic              unused_starve;

    assign unused_starve = (STARVE_MAX != 0) && (CNT_W != 0);
    assign force_if_c    = 1'b0;
`endif

    assign if_ok_c = if_req && !flush;

    // Grant, command latch and completion handling.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        drop_d      = drop_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // Grants are combinational, so gate them with the reset pin itself.
                if (rst) begin
                    if (force_if_c) begin
                        if_gnt = 1'b1;
                    end else if (ls_req) begin
                        ls_gnt = 1'b1;
                    end else if (if_ok_c) begin
                        if_gnt = 1'b1;
                    end
                end
                if (ls_gnt) begin
                    state_d     = BUSY_LS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_be_d    = ls_be;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                end else if (if_gnt) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            BUSY_IF: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    // A flush on the ack cycle itself also discards the data.
                    if (!(drop_q || flush)) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end
            end
            BUSY_LS: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    ls_rdata_d  = mem_rdata;
                    ls_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

`ifdef ARB_ANTI_STARVE_EN
    // Saturating count of LS wins taken while fetch was waiting.
    always_comb begin
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = '0;
        end else if (ls_gnt && if_ok_c && (starve_q != {CNT_W{1'b1}})) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // State and command registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign stall     = ls_req && !ls_rvalid_q;

endmodule
